relu_backward_stream: RTL
=========================

RELU_BACKWARD_STREAM -- requirements
Module: relu_backward_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the IEEE 754 word width (sign bit at WIDTH-1) of activations and gradients.
REQ-002 SHALL have parameter CNT_W, default 16, giving the zero-count statistics counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, input element valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept an input element.
REQ-007 SHALL have port in_act, input, WIDTH, forward-pass activation x.
REQ-008 SHALL have port in_grad, input, WIDTH, upstream gradient dL/dy.
REQ-009 SHALL have port in_last, input, 1, final element of a tensor/frame.
REQ-010 SHALL have port out_valid, output, 1, output element valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts output.
REQ-012 SHALL have port out_grad, output, WIDTH, gradient dL/dx.
REQ-013 SHALL have port out_last, output, 1, in_last delayed with its element.
REQ-014 SHALL have ports clear_stats, input, 1, and zero_count, output, CNT_W, present only under REQ-031.

Function
REQ-015 SHALL transfer input when in_valid and in_ready are both high at a rising edge; output when out_valid and out_ready are both high.
REQ-016 SHALL compute out_grad = in_grad when in_act[WIDTH-1]=0 and in_act[WIDTH-2:0]!=0; otherwise all-zero WIDTH bits (+0.0).
REQ-017 SHALL treat +0.0 and -0.0 activations as non-positive (gradient zeroed); positive-sign NaN/Inf as positive (gradient passed unchanged).
REQ-018 SHALL pass in_grad bit-exact when selected; no rounding, no sign or NaN modification.
REQ-019 SHALL hold results in a 2-entry in-order output buffer (count 0..2).
REQ-020 SHALL have latency 1: element accepted at edge N is on out_grad/out_last with out_valid high after edge N when buffer was empty.
REQ-021 SHALL drive in_ready = (count < 2) from registered state only; no combinational path from out_ready to in_ready.
REQ-022 SHALL drive out_valid = (count > 0); out_grad/out_last from the oldest entry, stable while out_valid high and out_ready low.
REQ-023 SHALL, on simultaneous accept and release, keep count unchanged and preserve order.
REQ-024 SHALL sustain one element per cycle when out_ready is held high.
REQ-025 SHALL never drop, duplicate, or reorder elements; out_last marks the same element as in_last.

Reset
REQ-026 SHALL, on rst_n low, immediately clear count to 0, giving in_ready=1 after release, out_valid=0, out_grad=0, out_last=0, zero_count=0.
REQ-027 SHALL discard buffered elements on reset mid-stream; no partial frame is resumed.
REQ-028 SHALL ignore in_valid and out_ready while rst_n is low.

Configuration
REQ-029 SHALL use macro RELU_BWD_STATS_EN to compile statistics in or out.
REQ-030 SHALL, without RELU_BWD_STATS_EN, omit clear_stats, zero_count, and the counter; datapath identical.
REQ-031 SHALL, with RELU_BWD_STATS_EN, increment zero_count by 1 per accepted input whose gradient is zeroed per REQ-016, saturating at 2^CNT_W-1.
REQ-032 SHALL, with RELU_BWD_STATS_EN, set zero_count to 0 on clear_stats high; clear wins over a same-cycle increment.

Verification
REQ-033 SHALL verify passthrough: WIDTH=16, act=16'h3C00 (1.0), grad=16'hB800 -> out_grad=16'hB800 one cycle later.
REQ-034 SHALL verify zeroing: act=16'hBC00, 16'h0000, 16'h8000 with grad=16'h4000 -> three outputs 16'h0000; zero_count=3 with RELU_BWD_STATS_EN.
REQ-035 SHALL verify backpressure: out_ready=0, push 3 elements -> first two accepted, in_ready=0 on third; out_ready=1 -> all three exit in order, out_last on the element sent with in_last.
REQ-036 SHALL verify throughput: out_ready=1, in_valid=1 for 100 cycles -> 100 outputs, in_ready never deasserted.
REQ-037 SHALL verify reset mid-operation: buffer full, rst_n low one cycle -> out_valid=0, count=0, zero_count=0, next input emerges after 1 cycle.
REQ-038 SHALL verify saturation: CNT_W=4, 20 zeroed inputs -> zero_count=15; clear_stats with a zeroed accept same cycle -> 0.

Source files
------------

// File: rtl/relu_backward_stream.sv
// ReLU backward pass on a stream: out_grad = in_grad where activation > 0, else +0.0.
// Latency 1 cycle from input accept to out_valid (empty buffer); 1 element/cycle sustained.
// Backpressure: 2-entry output buffer; in_ready deasserts only when both entries are held.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           input handshake; in_act, in_grad, in_last carried with it
//   out_valid/out_ready         output handshake; out_grad, out_last from the oldest entry
//   clear_stats, zero_count     zeroed-gradient statistics, present only when
//                               RELU_BWD_STATS_EN is defined
module relu_backward_stream #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_act,
   input  logic [WIDTH-1:0] in_grad,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_grad,
   output logic             out_last
`ifdef RELU_BWD_STATS_EN
   ,
   input  logic             clear_stats,
   output logic [CNT_W-1:0] zero_count
`endif
);

   // Buffer storage and occupancy
   logic [WIDTH-1:0] buf_grad [2];
   logic             buf_last [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;

   logic             acc;
   logic             rel;
   logic             act_pos;
   logic [WIDTH-1:0] grad_sel;

   // Handshakes depend only on registered occupancy, so out_ready never
   // reaches in_ready combinationally.
   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign acc       = in_valid & in_ready;
   assign rel       = out_valid & out_ready;

   // Positive means sign clear and any other bit set: +0.0 and -0.0 are not
   // positive, while +Inf and positive-sign NaN are.
   assign act_pos  = ~in_act[WIDTH-1] & (|in_act[WIDTH-2:0]);
   assign grad_sel = act_pos ? in_grad : '0;

   // Oldest entry is always at rd_ptr; it holds still until released.
   assign out_grad = buf_grad[rd_ptr];
   assign out_last = buf_last[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_grad[0] <= '0;
         buf_grad[1] <= '0;
         buf_last[0] <= 1'b0;
         buf_last[1] <= 1'b0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         if (acc) begin
            buf_grad[wr_ptr] <= grad_sel;
            buf_last[wr_ptr] <= in_last;
            wr_ptr           <= ~wr_ptr;
         end
         if (rel) begin
            rd_ptr <= ~rd_ptr;
         end
         // Simultaneous accept and release leaves the occupancy unchanged.
         case ({acc, rel})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef RELU_BWD_STATS_EN
   // Counts accepted elements whose gradient was zeroed; saturates, clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_count <= '0;
      end else if (clear_stats) begin
         zero_count <= '0;
      end else if (acc && !act_pos && (zero_count != {CNT_W{1'b1}})) begin
         zero_count <= zero_count + CNT_W'(1);
      end
   end
`else
   // Counter width has no user when statistics are compiled out.
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule
